mat_vec_arb: RTL and testbench
==============================

# mat_vec_arb

Two-requester round-robin arbiter and sequencer for the shared serial matrix-vector multiplier (`mat_vec_mul_ser`).
- Grants the multiplier to one requester at a time and pulses its start.
- Waits for its done, then streams the result memory out word by word through a valid/ready interface tagged with the requester id.
- Sits between the multiplier instance and the signer/verifier datapaths that both need `H·x` products.

## Interface
Parameters:
- `PROC_SIZE`, 64, result word width in bits; equals the multiplier's `PROC_SIZE`.
- `RES_WORDS`, 20, number of result words, i.e. the multiplier's `MAT_ROW_SIZE/PROC_SIZE`. 20 is L3: 1272 bits padded to 1280.
- `RES_AW`, `CLOG2(RES_WORDS)`, result address width.
- `TIMEOUT_CYCLES`, 65535, watchdog limit. Used only with `MV_ARB_TIMEOUT_EN`.

Ports:
- `i_clk`  in  1  clock. All logic on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset. The same reset also drives the multiplier.
- `i_req`  in  2  level request per requester; sampled only in IDLE.
- `o_gnt`  out  2  one-hot grant, held for the whole job.
- `o_busy`  out  1  high in every state except IDLE.
- `o_mv_start`  out  1  one-cycle start pulse to the multiplier.
- `i_mv_done`  in  1  done pulse from the multiplier.
- `o_res_en`  out  1  selects the arbiter's address on the multiplier result-memory read port.
- `o_res_addr`  out  `RES_AW`  result-memory read address.
- `i_res`  in  `PROC_SIZE`  result-memory read data; valid one cycle after its address.
- `o_res_data`  out  `PROC_SIZE`  streamed result word.
- `o_res_valid`  out  1  `o_res_data` is valid.
- `i_res_ready`  in  1  consumer accepts the word; a transfer occurs when valid and ready are both high.
- `o_res_last`  out  1  marks word `RES_WORDS-1`.
- `o_res_id`  out  1  index of the granted requester.
- `o_done`  out  2  one-cycle completion pulse to the granted requester.
- `o_err`  out  1  timeout flag, pulsed together with `o_done`.

## Operation
FSM states: IDLE, START, WAIT, READ, DRAIN, DONE.
- **IDLE:**
  - If any `i_req` is high, grant one requester and go to START.
  - If only one requests, it wins. If both request, the one not served last wins; `rr_last` after reset is 1, so requester 0 wins first.
  - `o_gnt` and `o_res_id` are registered on the transition.
- **START:** `o_mv_start`=1 for exactly this cycle, then go to WAIT.
- **WAIT:**
  - `o_res_en`=0, so the multiplier owns its own read port.
  - On `i_mv_done`, go to READ.
  - `i_mv_done` in any other state is ignored.
- **READ:**
  - `o_res_en`=1.
  - A read at `o_res_addr` is issued whenever (buffer occupancy + reads in flight) < 2. The address increments after each issued read, starting at 0.
  - After read `RES_WORDS-1` is issued, go to DRAIN.
- **Output buffer:** a 2-entry skid FIFO captures `i_res` one cycle after each issued read. `o_res_valid` equals "FIFO not empty". Words leave in ascending address order.
- **DRAIN:**
  - `o_res_en` stays 1 until the last read's data has been captured.
  - Once the word with `o_res_last`=1 transfers, go to DONE.
- **DONE:**
  - `o_done[g]`=1 for one cycle while `o_gnt` is still held. Then go to IDLE, where `o_gnt`=0.
  - `rr_last` is set to g.
- Once granted, deasserting `i_req` does not abort the job. A requester must drop `i_req` on its `o_done` cycle, otherwise it re-requests.
- Requests in non-IDLE states are not queued; they are simply seen at the next IDLE.

## Timing
- **Reset values:**
  - All outputs 0: `o_gnt`, `o_busy`, `o_mv_start`, `o_res_en`, `o_res_addr`, `o_res_valid`, `o_res_last`, `o_res_id`, `o_done`, `o_err`, `o_res_data`.
  - FIFO empty, state IDLE, `rr_last`=1.
- **Reset mid-job:** the job is discarded. No `o_done` and no further stream words are produced.
- **Request to start:** `i_req` high in cycle 0 gives `o_gnt` and `o_busy` in cycle 1 and `o_mv_start` in cycle 1.
- **Readout:**
  - `i_mv_done` in cycle D gives the first read issue (`o_res_en`=1, addr 0) in cycle D+1.
  - First `o_res_valid` appears in cycle D+3.
  - With `i_res_ready` held high: one word per cycle, last word in cycle D+2+`RES_WORDS`, `o_done` in cycle D+3+`RES_WORDS`.
- **Backpressure:** holding `i_res_ready` low stalls reads once the FIFO holds 2 words or 2 reads are outstanding. Data is never lost, duplicated or reordered. `o_res_data` is stable while valid and not ready.
- **Back-to-back grants:** minimum gap is one IDLE cycle between `o_done` and the next `o_gnt`.

## Configuration
`MV_ARB_TIMEOUT_EN`:
- **Defined:**
  - A counter runs in WAIT.
  - If `i_mv_done` has not arrived after `TIMEOUT_CYCLES` cycles in WAIT, skip READ/DRAIN and go to DONE with `o_err`=1 alongside `o_done`.
  - The counter clears on entry to WAIT.
- **Undefined:** no counter exists, `o_err` is tied to 0, and WAIT persists indefinitely.

## Test plan
- Reset, then `i_req`=01 with the multiplier model returning done 10 cycles after start:
  - `o_gnt`=01 and `o_mv_start` pulse in cycle 1.
  - 20 words at addresses 0..19 in order, `o_res_last` on word 19, `o_res_id`=0.
  - `o_done`=01 one cycle after the last transfer.
- `i_req`=11 held across three jobs: grants 01, 10, 01; `o_res_id` alternates 0, 1, 0.
- Random `i_res_ready` with 50% duty: all 20 words match a preloaded memory pattern `word k = k·0x0101…`, with no drops or duplicates.
- `i_rst` asserted mid-READ at word 7: all outputs 0 next cycle; a new request then starts cleanly from addr 0 with requester 0 favoured.
- `i_mv_done` pulsed while IDLE or in READ: no state change and no extra reads.
- With `MV_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50, a multiplier model that never signals done:
  - `o_done` and `o_err` pulse 50 cycles after WAIT entry, with no stream words.
  - Without the macro, the block stays in WAIT and `o_err`=0.

Source files
------------

// File: rtl/mat_vec_arb.sv
// Two-requester round-robin arbiter and result streamer for the shared serial matrix-vector multiplier.
// Define MV_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (limit TIMEOUT_CYCLES).
module mat_vec_arb #(
    parameter int PROC_SIZE      = 64,
    parameter int RES_WORDS      = 20,
    parameter int RES_AW         = $clog2(RES_WORDS),
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_req,
    output logic [1:0]           o_gnt,
    output logic                 o_busy,
    output logic                 o_mv_start,
    input  logic                 i_mv_done,
    output logic                 o_res_en,
    output logic [RES_AW-1:0]    o_res_addr,
    input  logic [PROC_SIZE-1:0] i_res,
    output logic [PROC_SIZE-1:0] o_res_data,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic                 o_res_last,
    output logic                 o_res_id,
    output logic [1:0]           o_done,
    output logic                 o_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [RES_AW-1:0] LAST_ADDR = RES_AW'(RES_WORDS - 1);

    state_t               state;
    logic                 rr_last;
    logic                 rd_inflight;
    logic                 rd_inflight_last;
    logic [1:0]           fifo_cnt;
    logic [PROC_SIZE-1:0] fifo_head;
    logic [PROC_SIZE-1:0] fifo_tail;
    logic                 head_last;
    logic                 tail_last;
    logic                 pop;
    logic                 issue;
    logic                 win;
    logic [1:0]           room_used;

    assign o_res_valid = (fifo_cnt != 2'd0);
    assign o_res_data  = fifo_head;
    assign o_res_last  = o_res_valid && head_last;

    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        pop       = o_res_valid && i_res_ready;
        // Count the word leaving this cycle as already gone so a full-rate stream never bubbles.
        room_used = fifo_cnt + {1'b0, rd_inflight} - {1'b0, pop};
        issue     = (state == ST_READ) && (room_used < 2'd2);
        win       = i_req[1] && (!i_req[0] || !rr_last);
    end

`ifdef MV_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wait_cnt;
`else
    assign o_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            rr_last          <= 1'b1;
            o_gnt            <= 2'b00;
            o_busy           <= 1'b0;
            o_mv_start       <= 1'b0;
            o_res_en         <= 1'b0;
            o_res_addr       <= '0;
            o_res_id         <= 1'b0;
            o_done           <= 2'b00;
            rd_inflight      <= 1'b0;
            rd_inflight_last <= 1'b0;
`ifdef MV_ARB_TIMEOUT_EN
            wait_cnt         <= '0;
            o_err            <= 1'b0;
`endif
        end else begin
            rd_inflight      <= issue;
            rd_inflight_last <= issue && (o_res_addr == LAST_ADDR);
            o_mv_start       <= 1'b0;
            o_done           <= 2'b00;
`ifdef MV_ARB_TIMEOUT_EN
            o_err            <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (|i_req) begin
                        o_gnt      <= win ? 2'b10 : 2'b01;
                        o_res_id   <= win;
                        o_busy     <= 1'b1;
                        o_mv_start <= 1'b1;
                        o_res_addr <= '0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
`ifdef MV_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_mv_done) begin
                        o_res_en <= 1'b1;
                        state    <= ST_READ;
                    end
`ifdef MV_ARB_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        o_done <= o_gnt;
                        o_err  <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`endif
                end
                ST_READ: begin
                    if (issue) begin
                        o_res_addr <= o_res_addr + RES_AW'(1);
                        if (o_res_addr == LAST_ADDR) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rd_inflight_last) begin
                        o_res_en <= 1'b0;
                    end
                    if (pop && o_res_last) begin
                        o_done <= o_gnt;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rr_last <= o_res_id;
                    o_gnt   <= 2'b00;
                    o_busy  <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Two-entry skid buffer; the head register is the streamed word.
    // NOTE: storage is reset too, because o_res_data must read 0 out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fifo_cnt  <= 2'd0;
            fifo_head <= '0;
            fifo_tail <= '0;
            head_last <= 1'b0;
            tail_last <= 1'b0;
        end else begin
            unique case ({rd_inflight, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        fifo_head <= i_res;
                        head_last <= rd_inflight_last;
                    end else begin
                        fifo_tail <= i_res;
                        tail_last <= rd_inflight_last;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    fifo_head <= fifo_tail;
                    head_last <= tail_last;
                    fifo_cnt  <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        fifo_head <= i_res;
                        head_last <= rd_inflight_last;
                    end else begin
                        fifo_head <= fifo_tail;
                        head_last <= tail_last;
                        fifo_tail <= i_res;
                        tail_last <= rd_inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_vec_arb.sv
// Self-checking bench for mat_vec_arb: multiplier/memory models, round-robin and stream reference.
// Exercises the watchdog path when MV_ARB_TIMEOUT_EN is defined.
module tb_mat_vec_arb;

    localparam int PROC_SIZE = 64;
    localparam int RES_WORDS = 20;
    localparam int RES_AW    = $clog2(RES_WORDS);
    localparam int TO_CYC    = 50;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic [1:0]           i_req;
    logic [1:0]           o_gnt;
    logic                 o_busy;
    logic                 o_mv_start;
    logic                 i_mv_done;
    logic                 o_res_en;
    logic [RES_AW-1:0]    o_res_addr;
    logic [PROC_SIZE-1:0] i_res;
    logic [PROC_SIZE-1:0] o_res_data;
    logic                 o_res_valid;
    logic                 i_res_ready;
    logic                 o_res_last;
    logic                 o_res_id;
    logic [1:0]           o_done;
    logic                 o_err;

    mat_vec_arb #(
        .PROC_SIZE      (PROC_SIZE),
        .RES_WORDS      (RES_WORDS),
        .RES_AW         (RES_AW),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .o_gnt       (o_gnt),
        .o_busy      (o_busy),
        .o_mv_start  (o_mv_start),
        .i_mv_done   (i_mv_done),
        .o_res_en    (o_res_en),
        .o_res_addr  (o_res_addr),
        .i_res       (i_res),
        .o_res_data  (o_res_data),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_last  (o_res_last),
        .o_res_id    (o_res_id),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        id;
        int          cyc;
    } xfer_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          mv_lat = 0;
    int          mv_cnt = 0;
    int          spur_at = -1;
    int          done_cnt = 0;
    int          last_served = 1;
    int          prev_done_cyc = 0;
    bit          rnd_ready = 1'b0;
    bit          hold_v = 1'b0;
    logic [63:0] hold_d;
    logic [63:0] mem [32];
    xfer_t       xq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, 64'({o_gnt, o_busy, o_mv_start, o_res_en, o_res_valid,
                                   o_res_last, o_res_id, o_done, o_err}), 64'd0);
        check({tag, "_addr"}, 64'(o_res_addr), 64'd0);
        check({tag, "_data"}, o_res_data, 64'd0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < 32; k++) mem[k] = {$urandom, $urandom};
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < 32; k++) mem[k] = 64'(k) * 64'h0101_0101_0101_0101;
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Result memory: registered read, data one cycle after its address.
    always @(posedge i_clk) i_res <= mem[o_res_addr];

    // Multiplier model: done pulse mv_lat cycles after start (never when mv_lat is 0).
    initial begin
        bit hit;
        i_mv_done = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            hit = 1'b0;
            if (i_rst) begin
                mv_cnt = 0;
            end else begin
                if (mv_cnt > 0) begin
                    mv_cnt--;
                    if (mv_cnt == 0) hit = 1'b1;
                end
                if (o_mv_start && mv_lat > 0) mv_cnt = mv_lat;
            end
            i_mv_done = hit || (cyc == spur_at);
        end
    end

    initial begin
        i_res_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            i_res_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Stream monitor: records transfers and checks hold-stability under backpressure.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (hold_v) begin
                check("hold_valid", 64'(o_res_valid), 64'd1);
                check("hold_data", o_res_data, hold_d);
            end
            if (o_res_valid && i_res_ready)
                xq.push_back('{data: o_res_data, last: o_res_last, id: o_res_id, cyc: cyc});
            if (o_done != 2'b00) done_cnt++;
        end
        hold_v = !i_rst && o_res_valid && !i_res_ready;
        hold_d = o_res_data;
    end

    task automatic run_job(input logic [1:0] req, input bit drop, input int lat,
                           input int spur_off, input bit gap);
        int         exp_id;
        int         g_cyc;
        int         d_cyc;
        int         guard;
        logic [1:0] exp_gnt;
        exp_id  = (req == 2'b01) ? 0 : (req == 2'b10) ? 1 : (last_served == 0 ? 1 : 0);
        exp_gnt = (exp_id == 0) ? 2'b01 : 2'b10;
        xq.delete();
        mv_lat = lat;
        i_req  = req;
        @(negedge i_clk);
        guard = 0;
        while (o_gnt == 2'b00 && guard < 50) begin
            @(negedge i_clk);
            guard++;
        end
        g_cyc = cyc;
        check("gnt", 64'(o_gnt), 64'(exp_gnt));
        check("gnt_id", 64'(o_res_id), 64'(exp_id));
        check("start_pulse", 64'(o_mv_start), 64'd1);
        check("busy", 64'(o_busy), 64'd1);
        if (gap) check("b2b_gap", 64'(g_cyc - prev_done_cyc), 64'd2);
        if (spur_off > 0) spur_at = g_cyc + lat + spur_off;
        @(negedge i_clk);
        check("start_one_cycle", 64'(o_mv_start), 64'd0);
        guard = 0;
        while (o_done == 2'b00 && guard < 4000) begin
            @(negedge i_clk);
            guard++;
        end
        d_cyc = cyc;
        check("done", 64'(o_done), 64'(exp_gnt));
        check("done_gnt_held", 64'(o_gnt), 64'(exp_gnt));
        check("done_err", 64'(o_err), 64'd0);
        check("word_count", 64'(xq.size()), 64'(RES_WORDS));
        for (int k = 0; k < RES_WORDS; k++) begin
            if (k < xq.size()) begin
                check($sformatf("word%0d_data", k), xq[k].data, mem[k]);
                check($sformatf("word%0d_last", k), 64'(xq[k].last), 64'(k == RES_WORDS - 1));
                check($sformatf("word%0d_id", k), 64'(xq[k].id), 64'(exp_id));
            end
        end
        if (xq.size() > 0) check("done_after_last", 64'(d_cyc - xq[$].cyc), 64'd1);
        if (!rnd_ready && xq.size() > 0) begin
            check("first_word_latency", 64'(xq[0].cyc - g_cyc), 64'(lat + 3));
            check("done_latency", 64'(d_cyc - g_cyc), 64'(lat + RES_WORDS + 3));
        end
        last_served   = exp_id;
        prev_done_cyc = d_cyc;
        if (drop) begin
            i_req = 2'b00;
            @(negedge i_clk);
            check("idle_gnt", 64'(o_gnt), 64'd0);
            check("idle_busy", 64'(o_busy), 64'd0);
        end
    endtask

    initial begin
        int guard;
        int base_done;
        int g_cyc;
        i_rst = 1'b1;
        i_req = 2'b00;
        fill_random();
        repeat (3) @(negedge i_clk);
        check_quiet("reset");
        i_rst = 1'b0;
        @(negedge i_clk);
        check_quiet("post_reset_idle");

        // Single requester, fixed 10-cycle multiplier latency.
        run_job(2'b01, 1'b1, 10, 0, 1'b0);

        // Fresh reset so requester 0 is favoured again.
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        last_served = 1;
        @(negedge i_clk);

        // Both requesting across three jobs: expect 0, 1, 0 with a one-cycle IDLE gap.
        fill_random();
        run_job(2'b11, 1'b0, $urandom_range(1, 15), 0, 1'b0);
        run_job(2'b11, 1'b0, $urandom_range(1, 15), 0, 1'b1);
        run_job(2'b11, 1'b1, $urandom_range(1, 15), 0, 1'b1);

        // Random backpressure against the k*0x0101... pattern.
        fill_pattern();
        rnd_ready = 1'b1;
        run_job(2'b10, 1'b1, $urandom_range(1, 15), 0, 1'b0);
        rnd_ready = 1'b0;
        @(negedge i_clk);

        // Stray done while IDLE must not start anything.
        base_done = done_cnt;
        spur_at = cyc + 1;
        repeat (4) begin
            @(negedge i_clk);
            check("spur_idle_busy", 64'({o_busy, o_res_en, o_gnt, o_res_valid}), 64'd0);
        end
        check("spur_idle_no_done", 64'(done_cnt), 64'(base_done));

        // Stray done during READ must not disturb the stream.
        fill_random();
        run_job(2'b01, 1'b1, 10, 5, 1'b0);

        // Reset in the middle of the readout.
        fill_random();
        xq.delete();
        mv_lat = 10;
        i_req = 2'b10;
        guard = 0;
        while (xq.size() < 7 && guard < 200) begin
            @(negedge i_clk);
            #1;
            guard++;
        end
        check("pre_reset_words", 64'(xq.size()), 64'd7);
        i_rst = 1'b1;
        i_req = 2'b00;
        @(negedge i_clk);
        check_quiet("mid_reset");
        i_rst = 1'b0;
        last_served = 1;
        base_done = done_cnt;
        repeat (40) @(negedge i_clk);
        check("rst_no_done", 64'(done_cnt), 64'(base_done));
        check("rst_no_words", 64'(xq.size()), 64'd7);
        run_job(2'b11, 1'b1, $urandom_range(1, 15), 0, 1'b0);

        // Multiplier that never answers.
        xq.delete();
        mv_lat = 0;
        i_req = 2'b01;
        @(negedge i_clk);
        guard = 0;
        while (o_gnt == 2'b00 && guard < 50) begin
            @(negedge i_clk);
            guard++;
        end
        g_cyc = cyc;
        check("hang_gnt", 64'(o_gnt), 64'd1);
`ifdef MV_ARB_TIMEOUT_EN
        guard = 0;
        while (o_done == 2'b00 && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
        check("to_done", 64'(o_done), 64'd1);
        check("to_err", 64'(o_err), 64'd1);
        check("to_latency", 64'(cyc - g_cyc), 64'(TO_CYC + 1));
        check("to_no_words", 64'(xq.size()), 64'd0);
        i_req = 2'b00;
        @(negedge i_clk);
        check("to_err_pulse", 64'({o_err, o_done}), 64'd0);
`else
        base_done = done_cnt;
        repeat (200) @(negedge i_clk);
        check("hang_busy", 64'(o_busy), 64'd1);
        check("hang_err", 64'(o_err), 64'd0);
        check("hang_res_en", 64'(o_res_en), 64'd0);
        check("hang_no_done", 64'(done_cnt), 64'(base_done));
        check("hang_no_words", 64'(xq.size()), 64'd0);
        i_req = 2'b00;
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
`endif
        @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
